// File: rtl/reg_loader_pkg.sv
// Shared types and defaults for the register-bank loader.
package reg_loader_pkg;

    localparam int NUM_REGS_DEF   = 32;
    localparam int ADDR_W_DEF     = 5;
    localparam int DATA_W_DEF     = 32;
    localparam int BYTES_PER_WORD = DATA_W_DEF / 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        WRITE   = 3'd2,
        CHECK   = 3'd3,
        FINISH  = 3'd4
    } state_e;

endpackage

// File: rtl/reg_bank_loader_if.sv
// Byte stream plus register-bank write/read pins; master is the loader side.
interface reg_bank_loader_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic [ADDR_W-1:0] wAddr;
    logic [DATA_W-1:0] wrData;
    logic              regWriteFlag;
    logic [ADDR_W-1:0] rAddr1;
    logic [DATA_W-1:0] data1;

    modport master (
        input  byte_in, byte_valid, data1,
        output byte_ready, wAddr, wrData, regWriteFlag, rAddr1
    );

    modport slave (
        output byte_in, byte_valid, data1,
        input  byte_ready, wAddr, wrData, regWriteFlag, rAddr1
    );
endinterface

// File: rtl/reg_bank_loader_word_assembler.sv
// MSB-first byte shift register with a byte counter; word_full flags the accept that completes a word.
module word_assembler
    import reg_loader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int BPW    = BYTES_PER_WORD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_accept,
    input  logic [7:0]        i_byte,
    output logic [DATA_W-1:0] o_word,
    output logic              o_word_full
);
    localparam int CNT_W = $clog2(BPW) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BPW - 1);

    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_word;

    // Byte counter and shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else if (i_clear) begin
            r_cnt  <= '0;
        end else if (i_accept) begin
            r_word <= {r_word[DATA_W-9:0], i_byte};
            r_cnt  <= (r_cnt == LAST_CNT) ? '0 : r_cnt + CNT_W'(1);
        end else begin
            r_cnt  <= r_cnt;
            r_word <= r_word;
        end
    end

    assign o_word      = r_word;
    assign o_word_full = i_accept && (r_cnt == LAST_CNT);
endmodule

// File: rtl/reg_bank_loader.sv
// Loads NUM_REGS words from a byte stream into the register bank write port.
// Optional read-back verify is compiled in with REG_LOADER_VERIFY_EN.
module reg_bank_loader
    import reg_loader_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    reg_bank_loader_if.master      bus,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [ADDR_W-1:0]      err_addr
);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_e            r_state;
    state_e            w_next_state;
    logic [ADDR_W-1:0] r_idx;
    logic [DATA_W-1:0] r_wr_data;
    logic [ADDR_W-1:0] r_waddr;
    logic              w_start_acc;
    logic              w_idx_inc;
    logic              w_set_err;
    logic              w_accept;
    logic              w_word_full;
    logic [DATA_W-1:0] w_word;

    assign w_accept = bus.byte_valid && (r_state == COLLECT);

    word_assembler #(.DATA_W(DATA_W), .BPW(DATA_W / 8)) u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (w_start_acc),
        .i_accept   (w_accept),
        .i_byte     (bus.byte_in),
        .o_word     (w_word),
        .o_word_full(w_word_full)
    );

    // Next-state decode; a clean verify falls through to the same idx decision as WRITE
    always_comb begin
        w_next_state = r_state;
        w_start_acc  = 1'b0;
        w_idx_inc    = 1'b0;
        w_set_err    = 1'b0;
        case (r_state)
            IDLE, FINISH: begin
                if (start) begin
                    w_next_state = COLLECT;
                    w_start_acc  = 1'b1;
                end else begin
                    w_next_state = r_state;
                end
            end
            COLLECT: begin
                if (w_word_full) begin
                    w_next_state = WRITE;
                end else begin
                    w_next_state = COLLECT;
                end
            end
`ifdef REG_LOADER_VERIFY_EN
            WRITE: begin
                w_next_state = CHECK;
            end
            CHECK: begin
                // Address 0 is $zero and always reads back 0
                if ((bus.data1 != r_wr_data) && (r_idx != '0)) begin
                    w_set_err    = 1'b1;
                    w_next_state = FINISH;
                end else if (r_idx == LAST_IDX) begin
                    w_next_state = FINISH;
                end else begin
                    w_idx_inc    = 1'b1;
                    w_next_state = COLLECT;
                end
            end
`else
            WRITE: begin
                if (r_idx == LAST_IDX) begin
                    w_next_state = FINISH;
                end else begin
                    w_idx_inc    = 1'b1;
                    w_next_state = COLLECT;
                end
            end
`endif
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State, index and held write-port registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_wr_data <= '0;
            r_waddr   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_start_acc) begin
                r_idx <= '0;
            end else if (w_idx_inc) begin
                r_idx <= r_idx + ADDR_W'(1);
            end else begin
                r_idx <= r_idx;
            end
            if (w_word_full) begin
                r_wr_data <= {w_word[DATA_W-9:0], bus.byte_in};
                r_waddr   <= r_idx;
            end else begin
                r_wr_data <= r_wr_data;
                r_waddr   <= r_waddr;
            end
        end
    end

    assign bus.byte_ready   = (r_state == COLLECT);
    assign bus.regWriteFlag = (r_state == WRITE);
    assign bus.wAddr        = r_waddr;
    assign bus.wrData       = r_wr_data;
    assign busy             = (r_state == COLLECT) || (r_state == WRITE) || (r_state == CHECK);
    assign done             = (r_state == FINISH);

`ifdef REG_LOADER_VERIFY_EN
    logic              r_error;
    logic [ADDR_W-1:0] r_err_addr;
    logic [ADDR_W-1:0] r_raddr;

    // Sticky verify error and read address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_error    <= 1'b0;
            r_err_addr <= '0;
            r_raddr    <= '0;
        end else begin
            if (w_start_acc) begin
                r_error    <= 1'b0;
                r_err_addr <= '0;
            end else if (w_set_err) begin
                r_error    <= 1'b1;
                r_err_addr <= r_idx;
            end else begin
                r_error    <= r_error;
                r_err_addr <= r_err_addr;
            end
            if (w_word_full) begin
                r_raddr <= r_idx;
            end else begin
                r_raddr <= r_raddr;
            end
        end
    end

    assign bus.rAddr1 = r_raddr;
    assign error      = r_error;
    assign err_addr   = r_err_addr;
`else
    logic w_unused_data1;
    assign w_unused_data1 = ^bus.data1;
    assign bus.rAddr1     = '0;
    assign error          = 1'b0;
    assign err_addr       = '0;
`endif
endmodule

// File: tb/tb_reg_bank_loader.sv
// Directed bench for reg_bank_loader with a bank model and a write scoreboard.
module tb_reg_bank_loader;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        done;
    logic        error;
    logic [4:0]  err_addr;
    logic        corrupt;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int wr_cnt   = 0;
    int rd_ptr   = 0;
    int s_cyc    = 0;
    int nbytes   = 0;

    logic [31:0] bank     [0:31];
    logic [4:0]  log_addr [0:255];
    logic [31:0] log_data [0:255];
    int          log_cyc  [0:255];
    logic [36:0] exp_q [$];

    reg_bank_loader_if #(.ADDR_W(5), .DATA_W(32)) bif ();

    reg_bank_loader dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bus     (bif),
        .busy    (busy),
        .done    (done),
        .error   (error),
        .err_addr(err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Register bank model: $zero reads 0, register 7 optionally corrupted on read
    always @(posedge clk) if (bif.regWriteFlag) bank[bif.wAddr] <= bif.wrData;
    assign bif.data1 = (bif.rAddr1 == 5'd0) ? 32'd0 :
                       (bank[bif.rAddr1] ^ ((corrupt && bif.rAddr1 == 5'd7) ? 32'h0000_0100 : 32'd0));

    always @(negedge clk) begin
        if (rst_n && bif.regWriteFlag && wr_cnt < 256) begin
            log_addr[wr_cnt] <= bif.wAddr;
            log_data[wr_cnt] <= bif.wrData;
            log_cyc[wr_cnt]  <= cyc;
            wr_cnt           <= wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        s_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        bif.byte_in    = b;
        bif.byte_valid = 1'b1;
        for (int t = 0; t < 64 && !ok; t++) begin
            @(negedge clk);
            if (bif.byte_ready) ok = 1'b1;
            tick();
        end
        bif.byte_valid = 1'b0;
        chk("byte_accept", {63'd0, ok}, 64'd1);
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int b = 3; b >= 0; b--) begin
            send_byte(w[b*8 +: 8]);
            nbytes++;
            if (gaps && (nbytes % 2 == 0)) tick();
        end
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        #1;
        chk("done_wait", {63'd0, seen}, 64'd1);
    endtask

    task automatic drain();
        logic [36:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_present", {63'd0, (wr_cnt > rd_ptr)}, 64'd1);
            if (wr_cnt > rd_ptr) begin
                chk("sb_addr", {59'd0, log_addr[rd_ptr]}, {59'd0, e[36:32]});
                chk("sb_data", {32'd0, log_data[rd_ptr]}, {32'd0, e[31:0]});
                rd_ptr++;
            end
        end
        chk("sb_extra", wr_cnt, rd_ptr);
    endtask

    task automatic abort_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; corrupt = 1'b0;
        bif.byte_in = 8'd0; bif.byte_valid = 1'b0;
        repeat (3) tick();
        chk("rst_byte_ready", {63'd0, bif.byte_ready}, 64'd0);
        chk("rst_wflag", {63'd0, bif.regWriteFlag}, 64'd0);
        chk("rst_waddr", {59'd0, bif.wAddr}, 64'd0);
        chk("rst_wrdata", {32'd0, bif.wrData}, 64'd0);
        chk("rst_raddr", {59'd0, bif.rAddr1}, 64'd0);
        chk("rst_busy_done", {62'd0, busy, done}, 64'd0);
        chk("rst_err", {58'd0, error, err_addr}, 64'd0);
        rst_n = 1'b1;
        tick();

        // Reset in the middle of the first word
        pulse_start();
        send_byte(8'hDE);
        send_byte(8'hAD);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_ready", {63'd0, bif.byte_ready}, 64'd0);
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
        chk("midrst_no_write", wr_cnt, 0);

        // First word timing with continuous bytes
        pulse_start();
        chk("start_ready", {63'd0, bif.byte_ready}, 64'd1);
        exp_q.push_back({5'd0, 32'h1234_5678});
        send_word(32'h1234_5678, 1'b0);
        @(negedge clk); #1;
        chk("first_wflag", {63'd0, bif.regWriteFlag}, 64'd1);
        if (wr_cnt > rd_ptr) chk("first_latency", log_cyc[rd_ptr] - s_cyc, 5);
        drain();
        abort_reset();

        // Full run with gaps and an ignored start while busy
        pulse_start();
        nbytes = 0;
        for (int k = 0; k < 32; k++) begin
            if (k == 10) begin
                start = 1'b1;
                tick();
                start = 1'b0;
                chk("busy_start_ignored", {63'd0, busy}, 64'd1);
            end
            exp_q.push_back({5'(k), 32'hA500_0000 + 32'(k)});
            send_word(32'hA500_0000 + 32'(k), 1'b1);
        end
        wait_done();
        chk("full_done", {63'd0, done}, 64'd1);
        chk("full_busy", {63'd0, busy}, 64'd0);
        chk("full_error", {63'd0, error}, 64'd0);
        drain();
        for (int k = 0; k < 32; k++) chk("bank_word", {32'd0, bank[k]}, {32'd0, 32'hA500_0000 + 32'(k)});

        // Restart from FINISH
        pulse_start();
        chk("restart_done_clr", {63'd0, done}, 64'd0);
        chk("restart_busy", {63'd0, busy}, 64'd1);
        exp_q.push_back({5'd0, 32'h1122_3344});
        send_word(32'h1122_3344, 1'b0);
        @(negedge clk); #1;
        drain();
        abort_reset();

`ifdef REG_LOADER_VERIFY_EN
        // Verify abort on a corrupted register 7
        corrupt = 1'b1;
        pulse_start();
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back({5'(k), 32'hC300_0000 + 32'(k)});
            send_word(32'hC300_0000 + 32'(k), 1'b0);
        end
        wait_done();
        chk("verify_error", {63'd0, error}, 64'd1);
        chk("verify_err_addr", {59'd0, err_addr}, 64'd7);
        chk("verify_ready_off", {63'd0, bif.byte_ready}, 64'd0);
        repeat (4) tick();
        drain();
        corrupt = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/reg_bank_loader.md
# reg_bank_loader

Sequential loader that fills the MIPS register bank through its write port from a byte stream, replacing simulation-only `$readmemb` initialisation with synthesizable hardware. It accepts bytes over a valid/ready handshake and assembles them MSB-first into 32-bit words. Each word is written to consecutive register addresses 0..NUM_REGS-1. It sits beside the register bank and drives the same `wAddr`/`wrData`/`regWriteFlag` pins the datapath's write-back stage uses; the top level muxes between the two using `busy`.

## Interface
- NUM_REGS, 32, number of registers loaded per run
- ADDR_W, 5, register address width
- DATA_W, 32, register data width; must be a multiple of 8
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a load run
- byte_in  in  8  stream data byte
- byte_valid  in  1  byte_in valid
- byte_ready  out  1  loader accepts a byte this cycle
- wAddr  out  ADDR_W  register bank write address
- wrData  out  DATA_W  register bank write data
- regWriteFlag  out  1  register bank write enable, one cycle per word
- rAddr1  out  ADDR_W  register bank read address (used for verify)
- data1  in  DATA_W  register bank read data; combinational from rAddr1
- busy  out  1  run in progress
- done  out  1  run finished; held until next accepted start
- error  out  1  verify mismatch; sticky until next accepted start
- err_addr  out  ADDR_W  address of first mismatch

## Operation
- The FSM has five states: IDLE, COLLECT, WRITE, CHECK and FINISH.
- IDLE → COLLECT on `start`. On entry, the loader clears idx, the byte count, `done`, `error` and `err_addr`.
- `start` is accepted in IDLE and FINISH. It is ignored in all other states.
- COLLECT asserts `byte_ready`. A byte transfers when `byte_valid && byte_ready`. The word shifts left by 8 and `byte_in` enters the LSBs, so the first byte is the MSB.
- When the DATA_W/8-th byte is accepted, the state goes to WRITE.
- In WRITE, `regWriteFlag`=1, `wAddr`=idx and `wrData`=assembled word for exactly one cycle.
- Leaving WRITE: go to CHECK if verify is compiled in. Otherwise, when idx = NUM_REGS-1, go to FINISH. Otherwise increment idx and return to COLLECT.
- In CHECK, `rAddr1`=idx and `data1` is compared with the held word.
  - On mismatch at idx≠0, set `error`=1 and `err_addr`=idx, then go to FINISH (abort).
  - Address 0 is never compared, because $zero is hardwired.
  - On match, take the same idx/next-state decision as WRITE.
- FINISH sets `done`=1 and `busy`=0 and waits for `start`.
- `busy`=1 in COLLECT, WRITE and CHECK.
- `byte_ready`=0 outside COLLECT. Bytes offered then are not consumed.
- `wAddr`, `wrData` and `rAddr1` hold their last values outside WRITE/CHECK. The bank only samples them when `regWriteFlag`=1.

## Timing
- Reset (asynchronous, immediate):
  - state IDLE
  - idx, byte count and word cleared
  - all outputs 0, including `regWriteFlag`
- A reset mid-run aborts the run with no further write. Bytes already accepted are discarded.
- `start` in cycle n puts the state in COLLECT at n+1, with `byte_ready`=1 at n+1.
- Per word, with back-to-back valid bytes:
  - without verify: 4 accept cycles plus 1 WRITE cycle = 5 cycles
  - with verify: 6 cycles
- The full run with continuous bytes takes 1 + 32×5 = 161 cycles from `start` to `done` (193 with verify).
- The `byte_valid` gaps stall COLLECT only, with no timeout.
- CHECK follows WRITE immediately, so the bank must write on the same rising edge that ends WRITE.
- idx wraps never; the run terminates at NUM_REGS-1.

## Configuration
- `REG_LOADER_VERIFY_EN` defined:
  - CHECK state exists and `rAddr1` is driven.
  - `error`/`err_addr` are functional.
- Not defined:
  - CHECK is removed and WRITE goes straight to the next-state decision.
  - `rAddr1`, `error` and `err_addr` are tied to 0, and `data1` is unused.

## Structure
- Package `reg_loader_pkg` holds:
  - the state enum (IDLE, COLLECT, WRITE, CHECK, FINISH)
  - the NUM_REGS/ADDR_W/DATA_W defaults
  - the BYTES_PER_WORD constant (DATA_W/8)
- One sub-module, `word_assembler`, provides the byte shift register and byte counter. It takes accept and clear inputs and produces word and word_full outputs.

## Test plan
- Reset during the first word → all outputs 0, `regWriteFlag` never pulses. A following `start` loads normally.
- `start`, then bytes 0x12,0x34,0x56,0x78 continuously → `regWriteFlag` for 1 cycle at cycle 5 after `start`, with `wAddr`=0 and `wrData`=0x12345678.
- Full run of 128 bytes encoding word k = 0xA5000000+k, with `byte_valid` dropped every 3rd cycle → 32 writes at `wAddr` 0..31 with matching data, then `done`=1 and `busy`=0. Bank contents are checked against the pattern.
- `start` pulsed while `busy` → ignored: idx is unchanged and no restart occurs.
- `start` pulsed in FINISH → `done` clears and a second run rewrites from `wAddr`=0.
- With `REG_LOADER_VERIFY_EN`, the bench forces the bank to corrupt register 7 → `error`=1, `err_addr`=7, `done`=1, and no write to register 8. The nonzero word at address 0 (read back as 0) raises no error.
